// File: rtl/water_supply_pkg.sv
// Shared types and helpers for the water supply valve sequencer.
// Holds the channel state enum, valve code builders and counter sizing.
package water_supply_pkg;

    localparam int VALVE_W_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD,
        ST_FAULT
    } state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [VALVE_W_MAX-1:0] valve_closed(input int width);
        logic [VALVE_W_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < VALVE_W_MAX; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [VALVE_W_MAX-1:0] valve_open(input int width);
        logic [VALVE_W_MAX-1:0] v;
        v = valve_closed(width);
        v[0] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/water_supply_valve_sequencer_if.sv
// Sensor/command bundle between level front end, sequencer and valve bank.
// The master side drives sensors and permissions; the slave drives valves.
interface water_supply_valve_sequencer_if #(
    parameter int CHANNELS = 4,
    parameter int VALVE_W  = 4
);

    logic [CHANNELS-1:0]         enable;
    logic [CHANNELS-1:0]         low_level;
    logic [CHANNELS-1:0]         high_level;
    logic [CHANNELS-1:0]         fault_clear;
    logic [CHANNELS*VALVE_W-1:0] valve;
    logic [CHANNELS-1:0]         filling;
    logic [CHANNELS-1:0]         fault;
    logic                        fault_any;

    modport master (
        output enable,
        output low_level,
        output high_level,
        output fault_clear,
        input  valve,
        input  filling,
        input  fault,
        input  fault_any
    );

    modport slave (
        input  enable,
        input  low_level,
        input  high_level,
        input  fault_clear,
        output valve,
        output filling,
        output fault,
        output fault_any
    );

endinterface

// File: rtl/water_supply_channel.sv
// One tank: IDLE/FILL/HOLD/FAULT machine with conflict debounce,
// fill timeout and post-close hold-off counters.
module water_supply_channel
    import water_supply_pkg::*;
#(
    parameter int VALVE_W         = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int FILL_TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic               i_low,
    input  logic               i_high,
    input  logic               i_fault_clear,
    input  logic               i_grant,
    output logic               o_req,
    output logic [VALVE_W-1:0] o_valve,
    output logic               o_filling,
    output logic               o_fault
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int FILL_W = cnt_width(FILL_TIMEOUT);

    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [FILL_W-1:0] FILL_LAST =
        FILL_W'((FILL_TIMEOUT == 0) ? 0 : FILL_TIMEOUT - 1);

    localparam logic [VALVE_W_MAX-1:0] OPEN_FULL   = valve_open(VALVE_W);
    localparam logic [VALVE_W_MAX-1:0] CLOSED_FULL = valve_closed(VALVE_W);
    localparam logic [VALVE_W-1:0]     VALVE_OPEN  = OPEN_FULL[VALVE_W-1:0];
    localparam logic [VALVE_W-1:0]     VALVE_SHUT  = CLOSED_FULL[VALVE_W-1:0];

    state_t             r_state;
    logic [DEB_W-1:0]   r_deb;
    logic [HOLD_W-1:0]  r_hold;
    logic [FILL_W-1:0]  r_fill;

    logic               w_conflict;
    logic [DEB_W-1:0]   w_deb_next;
    logic               w_stable;
    logic               w_timeout;

    assign w_conflict = i_high & ~i_low;

    always_comb begin
        w_deb_next = '0;
        if (w_conflict) begin
            w_deb_next = (r_deb == DEB_MAX) ? DEB_MAX : r_deb + 1'b1;
        end
    end

    // Stable on the cycle the run of conflicts reaches the threshold
    assign w_stable  = (w_deb_next == DEB_MAX);
    assign w_timeout = (FILL_TIMEOUT != 0) && (r_fill == FILL_LAST);

    assign o_req = (r_state == ST_IDLE) & i_enable & ~i_low & ~w_conflict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_deb   <= '0;
            r_hold  <= '0;
            r_fill  <= '0;
        end else begin
            r_deb <= w_deb_next;
            if (w_stable) begin
                r_state <= ST_FAULT;
                r_hold  <= '0;
                r_fill  <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (o_req && i_grant) begin
                            r_state <= ST_FILL;
                            r_fill  <= '0;
                        end
                    end
                    ST_FILL: begin
                        if (i_high || !i_enable) begin
                            r_state <= ST_HOLD;
                            r_hold  <= '0;
                        end else if (w_timeout) begin
                            r_state <= ST_FAULT;
                            r_fill  <= '0;
                        end else if (FILL_TIMEOUT != 0) begin
                            r_fill <= r_fill + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (r_hold == HOLD_LAST) begin
                            r_state <= ST_IDLE;
                            r_hold  <= '0;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        // A clear seen during conflict is simply lost
                        if (i_fault_clear && !w_conflict) begin
                            r_state <= ST_HOLD;
                            r_hold  <= '0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_valve   = (r_state == ST_FILL) ? VALVE_OPEN : VALVE_SHUT;
    assign o_filling = (r_state == ST_FILL);
    assign o_fault   = (r_state == ST_FAULT);

endmodule

// File: rtl/water_supply_valve_sequencer.sv
// Multi-tank fill sequencer: one channel FSM per tank plus fault summary.
// WATER_SUPPLY_SINGLE_OPEN_EN adds a round-robin single-valve-open arbiter.
module water_supply_valve_sequencer
    import water_supply_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int VALVE_W         = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int FILL_TIMEOUT    = 1024
) (
    input logic clk,
    input logic rst_n,
    water_supply_valve_sequencer_if.slave bus
);

    logic [CHANNELS-1:0] w_req;
    logic [CHANNELS-1:0] w_grant;
    logic [CHANNELS-1:0] w_filling;
    logic [CHANNELS-1:0] w_fault;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        water_supply_channel #(
            .VALVE_W        (VALVE_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .FILL_TIMEOUT   (FILL_TIMEOUT)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_enable     (bus.enable[g]),
            .i_low        (bus.low_level[g]),
            .i_high       (bus.high_level[g]),
            .i_fault_clear(bus.fault_clear[g]),
            .i_grant      (w_grant[g]),
            .o_req        (w_req[g]),
            .o_valve      (bus.valve[g*VALVE_W +: VALVE_W]),
            .o_filling    (w_filling[g]),
            .o_fault      (w_fault[g])
        );
    end

`ifdef WATER_SUPPLY_SINGLE_OPEN_EN
    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic             w_gnt_any;
    int               w_idx;

    // Search begins at r_ptr; only grant while every valve is shut
    always_comb begin
        w_grant    = '0;
        w_ptr_next = r_ptr;
        w_gnt_any  = 1'b0;
        w_idx      = 0;
        if (~|w_filling) begin
            for (int k = 0; k < CHANNELS; k++) begin
                w_idx = (int'(r_ptr) + k) % CHANNELS;
                if (!w_gnt_any && w_req[w_idx]) begin
                    w_grant[w_idx] = 1'b1;
                    w_gnt_any      = 1'b1;
                    w_ptr_next     = PTR_W'((w_idx + 1) % CHANNELS);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_gnt_any) begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    logic w_unused_req;

    assign w_unused_req = ^w_req;
    assign w_grant      = '1;
`endif

    assign bus.filling   = w_filling;
    assign bus.fault     = w_fault;
    assign bus.fault_any = |w_fault;

endmodule

// File: tb/tb_water_supply_valve_sequencer.sv
// Directed and random bench for the valve sequencer against a tank-level model.
// Model honours WATER_SUPPLY_SINGLE_OPEN_EN when defined.
module tb_water_supply_valve_sequencer;

    localparam int CH  = 4;
    localparam int VW  = 4;
    localparam int DEB = 4;
    localparam int HLD = 16;
    localparam int TO  = 32;

    localparam int PH_IDLE  = 0;
    localparam int PH_FILL  = 1;
    localparam int PH_HOLD  = 2;
    localparam int PH_FAULT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    water_supply_valve_sequencer_if #(.CHANNELS(CH), .VALVE_W(VW)) bus ();

    water_supply_valve_sequencer #(
        .CHANNELS       (CH),
        .VALVE_W        (VW),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HLD),
        .FILL_TIMEOUT   (TO)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    int ph [CH];
    int run[CH];
    int age[CH];
    int ptr;

    int lvl[CH];
    int burst[CH];
    logic [CH-1:0] t_en, t_lo, t_hi, t_fc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            ph[i] = PH_IDLE;
            run[i] = 0;
            age[i] = 0;
        end
        ptr = 0;
    endtask

    function automatic logic [31:0] expect_vec();
        logic [CH*VW-1:0] v;
        logic [CH-1:0] f, x;
        for (int i = 0; i < CH; i++) begin
            v[i*VW +: VW] = (ph[i] == PH_FILL) ? 4'b1110 : 4'b1111;
            f[i] = (ph[i] == PH_FILL);
            x[i] = (ph[i] == PH_FAULT);
        end
        return 32'({v, f, x, |x});
    endfunction

    task automatic model_step();
        bit wants[CH];
        bit gnt[CH];
        bit conflict;
        bit anyfill;
        anyfill = 0;
        for (int i = 0; i < CH; i++) begin
            conflict = bus.high_level[i] && !bus.low_level[i];
            wants[i] = (ph[i] == PH_IDLE) && bus.enable[i]
                       && !bus.low_level[i] && !conflict;
            if (ph[i] == PH_FILL) anyfill = 1;
            gnt[i] = 1;
        end
`ifdef WATER_SUPPLY_SINGLE_OPEN_EN
        for (int i = 0; i < CH; i++) gnt[i] = 0;
        if (!anyfill) begin
            for (int k = 0; k < CH; k++) begin
                int i;
                i = (ptr + k) % CH;
                if (wants[i]) begin
                    gnt[i] = 1;
                    ptr = (i + 1) % CH;
                    break;
                end
            end
        end
`endif
        for (int i = 0; i < CH; i++) begin
            conflict = bus.high_level[i] && !bus.low_level[i];
            run[i] = conflict ? ((run[i] < DEB) ? run[i] + 1 : DEB) : 0;
            if (run[i] == DEB) begin
                ph[i] = PH_FAULT;
                age[i] = 0;
            end else if (ph[i] == PH_IDLE) begin
                if (wants[i] && gnt[i]) begin
                    ph[i] = PH_FILL;
                    age[i] = 0;
                end
            end else if (ph[i] == PH_FILL) begin
                age[i]++;
                if (bus.high_level[i] || !bus.enable[i]) begin
                    ph[i] = PH_HOLD;
                    age[i] = 0;
                end else if (TO != 0 && age[i] == TO) begin
                    ph[i] = PH_FAULT;
                    age[i] = 0;
                end
            end else if (ph[i] == PH_HOLD) begin
                age[i]++;
                if (age[i] == HLD) begin
                    ph[i] = PH_IDLE;
                    age[i] = 0;
                end
            end else begin
                if (bus.fault_clear[i] && !conflict) begin
                    ph[i] = PH_HOLD;
                    age[i] = 0;
                end
            end
        end
    endtask

    task automatic drive(input logic [CH-1:0] en, input logic [CH-1:0] lo,
                         input logic [CH-1:0] hi, input logic [CH-1:0] fc);
        bus.enable      = en;
        bus.low_level   = lo;
        bus.high_level  = hi;
        bus.fault_clear = fc;
    endtask

    task automatic drive0(input logic en, input logic lo, input logic hi,
                          input logic fc);
        drive({3'b000, en}, {3'b111, lo}, {3'b000, hi}, {3'b000, fc});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cycle", 32'({bus.valve, bus.filling, bus.fault, bus.fault_any}),
              expect_vec());
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valve", 32'(bus.valve), 32'hFFFF);
        check("async_rst_status",
              32'({bus.filling, bus.fault, bus.fault_any}), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        drive('0, '1, '0, '0);
        for (int i = 0; i < CH; i++) begin
            lvl[i] = 1;
            burst[i] = 0;
        end
        @(negedge clk);
        check("reset_valve", 32'(bus.valve), 32'hFFFF);
        check("reset_status",
              32'({bus.filling, bus.fault, bus.fault_any}), 32'h0);
        rst_n = 1'b1;

        drive0(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("fill_open", 32'(bus.valve[3:0]), 32'hE);
        drive0(1'b1, 1'b1, 1'b0, 1'b0);
        ticks(2);
        drive0(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("high_close", 32'(bus.valve[3:0]), 32'hF);
        drive0(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < HLD; k++) begin
            tick();
            check("hold_closed", 32'(bus.filling[0]), 32'h0);
        end
        tick();
        check("reopen", 32'(bus.filling[0]), 32'h1);

        ticks(3);
        reset_pulse();
        tick();
        check("post_rst_open", 32'(bus.valve[3:0]), 32'hE);

        drive0(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20);
        drive0(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        drive0(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("short_conflict", 32'(bus.fault[0]), 32'h0);
        drive0(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        check("conflict_3", 32'(bus.fault[0]), 32'h0);
        tick();
        check("conflict_4", 32'(bus.fault[0]), 32'h1);
        check("fault_valve", 32'(bus.valve[3:0]), 32'hF);

        drive0(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("clear_dropped", 32'(bus.fault[0]), 32'h1);
        drive0(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("still_fault", 32'(bus.fault_any), 32'h1);
        drive0(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check("cleared", 32'(bus.fault[0]), 32'h0);
        drive0(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20);

        drive0(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(TO);
        check("pre_timeout", 32'(bus.filling[0]), 32'h1);
        tick();
        check("timeout", 32'(bus.fault[0]), 32'h1);
        drive0(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        drive0(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20);

        drive0(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(TO);
        drive0(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("high_at_limit_fault", 32'(bus.fault[0]), 32'h0);
        check("high_at_limit_fill", 32'(bus.filling[0]), 32'h0);
        drive0(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20);

        drive('1, '0, '0, '0);
        ticks(40);

        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < CH; i++) begin
                if (burst[i] == 0 && $urandom_range(0, 39) == 0)
                    burst[i] = int'($urandom_range(1, 6));
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1)
                        lvl[i] = (lvl[i] < 2) ? lvl[i] + 1 : 2;
                    else
                        lvl[i] = (lvl[i] > 0) ? lvl[i] - 1 : 0;
                end
                t_en[i] = ($urandom_range(0, 7) != 0);
                t_fc[i] = ($urandom_range(0, 5) == 0);
                if (burst[i] > 0) begin
                    t_lo[i] = 1'b0;
                    t_hi[i] = 1'b1;
                    burst[i]--;
                end else begin
                    t_lo[i] = (lvl[i] >= 1);
                    t_hi[i] = (lvl[i] >= 2);
                end
            end
            drive(t_en, t_lo, t_hi, t_fc);
            tick();
            if (n == 400) reset_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/water_supply_valve_sequencer.md
Name: water_supply_valve_sequencer

Overview:
- Per-tank fill controller for CHANNELS independent water tanks.
- Each channel runs a clocked state machine on its low/high level sensors.
- Each channel drives a VALVE_W-bit valve command word with fill hysteresis, a debounced sensor-conflict fault, a post-close hold-off and a fill timeout.
- Sits between the level-sensor front end (inputs already synchronous to clk) and the valve driver bank.

Parameters:
- CHANNELS, 4, number of tanks/valves.
- VALVE_W, 4, valve command word width per channel (≥1).
- DEBOUNCE_CYCLES, 4, consecutive conflict cycles needed to enter FAULT (≥1).
- HOLD_CYCLES, 16, minimum closed cycles after a fill ends (≥1).
- FILL_TIMEOUT, 1024, max cycles in FILL before FAULT; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  CHANNELS  per-channel fill permission.
- low_level  input  CHANNELS  1 = water at/above the low sensor.
- high_level  input  CHANNELS  1 = water at/above the high sensor.
- fault_clear  input  CHANNELS  per-channel single-cycle fault acknowledge.
- valve  output  CHANNELS*VALVE_W  channel i occupies bits [i*VALVE_W +: VALVE_W].
- filling  output  CHANNELS  1 while the channel is in FILL.
- fault  output  CHANNELS  1 while the channel is in FAULT.
- fault_any  output  1  OR of fault.

Behaviour:
- Valve codes: CLOSED = all ones; OPEN = all ones except bit 0 = 0. The valve is OPEN only in FILL.
- Conflict[i] = high_level[i] & ~low_level[i].
- Debounce counter:
  - Increments on each conflict cycle and saturates at DEBOUNCE_CYCLES.
  - Clears to 0 on any non-conflict cycle.
  - conflict_stable = (counter reaches DEBOUNCE_CYCLES).
- States per channel: IDLE, FILL, HOLD, FAULT. Evaluation is in priority order, first match wins.
- Any state, conflict_stable → FAULT (highest priority).
- IDLE:
  - enable & ~low_level & no conflict (and grant, see Optional Feature) → FILL.
  - Otherwise stay.
- FILL:
  - high_level → HOLD.
  - else ~enable → HOLD.
  - else fill timer == FILL_TIMEOUT (when FILL_TIMEOUT ≠ 0) → FAULT.
  - Fill timer clears on FILL entry and counts each FILL cycle.
- HOLD:
  - Hold counter clears on entry.
  - Go to IDLE after exactly HOLD_CYCLES cycles in HOLD.
  - enable is ignored while in HOLD.
- FAULT:
  - fault_clear & debounce counter == 0 → HOLD.
  - A fault_clear arriving while conflict is present is dropped, not queued.
- Outputs decode combinationally from the state register:
  - A sensor/enable change sampled at edge k is visible on valve/filling/fault after edge k.
  - Latency is one cycle.
- Simultaneous events:
  - high_level and timeout expiring in the same cycle → HOLD.
  - conflict_stable together with any other condition → FAULT.
- Reset (async assert, any time including mid-fill):
  - All channels go to IDLE; all counters = 0.
  - valve = all ones (CLOSED), filling = 0, fault = 0, fault_any = 0.
  - Deassertion takes effect on the next rising clk edge.
- Counter widths: $clog2(max+1) of the respective parameter; no wrap-around (all counters saturate or clear).

Optional Feature:
- Macro: WATER_SUPPLY_SINGLE_OPEN_EN.
- Defined:
  - At most one channel may be in FILL at any time (supply pressure limit).
  - An IDLE channel requesting fill needs a grant.
  - A round-robin arbiter grants only when no channel is in FILL.
  - The search starts at the index after the last granted channel; the pointer resets to channel 0.
  - A waiting channel stays IDLE with its valve CLOSED.
- Undefined: no arbiter; every channel fills independently; the grant is tied to 1.

Decomposition:
- Package water_supply_pkg holds:
  - the state enum (IDLE, FILL, HOLD, FAULT);
  - functions valve_closed(width) and valve_open(width);
  - the clog2-based counter width helper.
- Sub-module water_supply_channel contains one channel's FSM and its debounce, fill and hold counters.
- The top instantiates CHANNELS copies, plus the optional arbiter logic and the fault_any OR.

Test Plan (VALVE_W=4, DEBOUNCE=4, HOLD=16, FILL_TIMEOUT=32):
- Reset mid-fill: ch0 in FILL, pulse rst_n low → valve[3:0]=4'b1111 immediately, filling=0; after release with low_level=0, enable=1 → 4'b1110 one cycle later.
- Normal fill: enable=1, low=0, high=0 → 4'b1110; raise low, then high → 4'b1111; filling stays low for 16 cycles even with low dropped, then reopens.
- Conflict debounce: high=1, low=0 for 3 cycles then clear → no fault; hold 4 cycles → fault[0]=1, valve CLOSED.
- Fault clear: fault_clear while conflict persists → stays FAULT; remove conflict, pulse fault_clear → HOLD, then IDLE after 16 cycles.
- Timeout: FILL with high never rising → fault after 32 FILL cycles. high rising on cycle 32 → HOLD, no fault.
- WATER_SUPPLY_SINGLE_OPEN_EN: ch0–ch3 all request → filling one-hot, order 0,1,2,3.
